// File: rtl/quick_cpu_sequencer.sv
// Instruction sequencer for a tiny 8-bit CPU. It fetches one byte per instruction,
// decodes it into register-file write controls, and supports free-run, single-step and halt.
module quick_cpu_sequencer #(
  parameter int unsigned PC_W = 8,
  parameter int unsigned TMO  = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            step,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic            rf_we,
  output logic            rf_sel,
  output logic            rf_src,
  output logic [7:0]      imm,
  output logic [1:0]      alu_op,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            fault
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFetch = 2'b01,
    StExec  = 2'b10,
    StHalt  = 2'b11
  } state_e;

  localparam logic [1:0] OpAlu  = 2'b00;
  localparam logic [1:0] OpLdi  = 2'b01;
  localparam logic [1:0] OpJmp  = 2'b10;
  localparam logic [1:0] OpHalt = 2'b11;

  localparam logic [3:0] TmoLast = 4'(TMO - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            step_q, step_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            fault_q, fault_d;

  logic [1:0]      opcode;
  logic [PC_W-1:0] jmp_target;
  logic [PC_W-1:0] pc_inc;

  assign opcode     = ir_q[7:6];
  assign jmp_target = PC_W'({2'b00, ir_q[5:0]});
  assign pc_inc     = pc_q + PC_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      step_q  <= 1'b0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    fault_d  = fault_q;
    imem_req = 1'b0;
    rf_we    = 1'b0;
    rf_sel   = 1'b0;
    rf_src   = 1'b0;
    imm      = 8'h00;
    alu_op   = 2'b00;
    halted   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // run has priority, so a step pulse seen together with run is dropped
        if (run) begin
          state_d = StFetch;
          cnt_d   = '0;
        end else if (step) begin
          step_d  = 1'b1;
          state_d = StFetch;
          cnt_d   = '0;
        end
      end

      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = StExec;
        end else if (cnt_q == TmoLast) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      StExec: begin
        unique case (opcode)
          OpAlu: begin
            rf_we  = 1'b1;
            rf_sel = ir_q[3];
            alu_op = ir_q[5:4];
            pc_d   = pc_inc;
          end
          OpLdi: begin
            rf_we  = 1'b1;
            rf_sel = ir_q[5];
            rf_src = 1'b1;
            imm    = {3'b000, ir_q[4:0]};
            pc_d   = pc_inc;
          end
          OpJmp: begin
            pc_d = jmp_target;
          end
          OpHalt: begin
            pc_d = pc_q;
          end
          default: begin
            pc_d = pc_q;
          end
        endcase

        if (opcode == OpHalt) begin
          state_d = StHalt;
        end else if (run && !step_q) begin
          state_d = StFetch;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
          step_d  = 1'b0;
        end
      end

      StHalt: begin
        halted = 1'b1;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_quick_cpu_sequencer.sv
// Directed bench for quick_cpu_sequencer: a 1-cycle-latency program memory model
// plus write/fetch logs, checked with immediate assertions.
module tb_quick_cpu_sequencer;

  logic       clk;
  logic       rst;
  logic       run;
  logic       step;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic       rf_we;
  logic       rf_sel;
  logic       rf_src;
  logic [7:0] imm;
  logic [1:0] alu_op;
  logic [7:0] pc;
  logic       halted;
  logic       fault;

  logic [7:0] mem [256];
  logic       ack_q;
  logic       ack_en;
  logic       ack_force;

  int          checks;
  int          errors;
  int          cyc;
  int          req_cycles;
  int          quiet_viol;
  logic [11:0] we_log[$];
  int          we_cyc[$];
  logic [7:0]  ack_addr[$];
  int          ack_cyc[$];

  logic [31:0] all_out;
  assign all_out = {imem_req, imem_addr, rf_we, rf_sel, rf_src, imm, alu_op, pc, halted, fault};

  quick_cpu_sequencer #(
    .PC_W(8),
    .TMO (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step      (step),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .rf_we     (rf_we),
    .rf_sel    (rf_sel),
    .rf_src    (rf_src),
    .imm       (imm),
    .alu_op    (alu_op),
    .pc        (pc),
    .halted    (halted),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers one cycle after it sees a request
  always @(posedge clk or posedge rst) begin
    if (rst) ack_q <= 1'b0;
    else     ack_q <= ack_en && imem_req && !ack_q;
  end
  assign imem_ack   = ack_q | ack_force;
  assign imem_rdata = mem[imem_addr];

  always @(posedge clk) begin
    if (!rst) begin
      if (imem_req) req_cycles <= req_cycles + 1;
      if (imem_req && imem_ack) begin
        ack_addr.push_back(imem_addr);
        ack_cyc.push_back(cyc);
      end
      if (rf_we) begin
        we_log.push_back({rf_sel, rf_src, alu_op, imm});
        we_cyc.push_back(cyc);
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if ((imem_req || halted) && ({rf_we, rf_sel, rf_src, imm, alu_op} != 13'h0))
      quiet_viol <= quiet_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    run  = 1'b0;
    step = 1'b0;
    rst  = 1'b1;
    #1;
    check("reset_outputs_zero", all_out, 32'h0);
    tick(2);
    we_log.delete();
    we_cyc.delete();
    ack_addr.delete();
    ack_cyc.delete();
    req_cycles = 0;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int saved;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    req_cycles = 0;
    quiet_viol = 0;
    rst        = 1'b1;
    run        = 1'b0;
    step       = 1'b0;
    ack_en     = 1'b1;
    ack_force  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hC0;

    tick(2);
    check("por_outputs_zero", all_out, 32'h0);

    // Program: LDI A,5 / LDI B,1 / ALU op0 -> A / HALT
    mem[0] = 8'h45;
    mem[1] = 8'h61;
    mem[2] = 8'h00;
    mem[3] = 8'hC0;
    do_reset();
    run = 1'b1;
    n = 0;
    while (!halted && n < 60) begin tick(1); n++; end
    check("prog_halted", {31'b0, halted}, 32'd1);
    check("prog_pc", {24'b0, pc}, 32'd3);
    check("prog_fault", {31'b0, fault}, 32'd0);
    check("prog_halt_req", {31'b0, imem_req}, 32'd0);
    check("prog_nwrites", we_log.size(), 32'd3);
    check("prog_w0_ldi_a5", {20'b0, we_log[0]}, 32'h405);
    check("prog_w1_ldi_b1", {20'b0, we_log[1]}, 32'hC01);
    check("prog_w2_alu_a", {20'b0, we_log[2]}, 32'h000);
    check("lat_ack_to_we", we_cyc[0] - ack_cyc[0], 32'd1);
    check("lat_ack_to_ack", ack_cyc[1] - ack_cyc[0], 32'd3);

    // HALT is terminal even for step
    saved = req_cycles;
    run  = 1'b0;
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(4);
    check("halt_sticky", {31'b0, halted}, 32'd1);
    check("halt_no_fetch", req_cycles, saved);

    // Single step
    mem[0] = 8'h45;
    mem[1] = 8'hC0;
    do_reset();
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(8);
    check("step_nacks", ack_addr.size(), 32'd1);
    check("step_addr", {24'b0, ack_addr[0]}, 32'd0);
    check("step_nwrites", we_log.size(), 32'd1);
    check("step_write", {20'b0, we_log[0]}, 32'h405);
    check("step_pc", {24'b0, pc}, 32'd1);
    check("step_req_cycles", req_cycles, 32'd2);
    check("step_idle", {30'b0, imem_req, halted}, 32'd0);

    // Stray ack in IDLE must be ignored
    ack_force = 1'b1;
    tick(3);
    ack_force = 1'b0;
    tick(1);
    check("stray_ack_pc", {24'b0, pc}, 32'd1);
    check("stray_ack_writes", we_log.size(), 32'd1);
    check("stray_ack_req", req_cycles, 32'd2);

    // JMP 10, then ALU op3 -> B up to 255 and wrap to 0
    for (int i = 0; i < 256; i++) mem[i] = 8'h38;
    mem[0] = 8'h8A;
    do_reset();
    run = 1'b1;
    n = 0;
    while (ack_addr.size() < 249 && n < 2000) begin tick(1); n++; end
    check("jmp_progress", {31'b0, ack_addr.size() >= 249}, 32'd1);
    check("jmp_target", {24'b0, ack_addr[1]}, 32'd10);
    check("jmp_alu_write", {20'b0, we_log[0]}, 32'hB00);
    check("wrap_at_255", {24'b0, ack_addr[246]}, 32'd255);
    check("wrap_to_0", {24'b0, ack_addr[247]}, 32'd0);
    check("wrap_rejump", {24'b0, ack_addr[248]}, 32'd10);
    run = 1'b0;
    tick(6);
    check("run_drop_idle", {30'b0, imem_req, halted}, 32'd0);

    // Fetch timeout
    do_reset();
    ack_en = 1'b0;
    run    = 1'b1;
    n = 0;
    while (!halted && n < 40) begin tick(1); n++; end
    check("tmo_halted", {31'b0, halted}, 32'd1);
    check("tmo_fault", {31'b0, fault}, 32'd1);
    check("tmo_req_cycles", req_cycles, 32'd15);
    check("tmo_no_write", we_log.size(), 32'd0);
    check("tmo_pc", {24'b0, pc}, 32'd0);
    ack_en = 1'b1;

    // Reset mid-fetch
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    do_reset();
    run = 1'b1;
    n = 0;
    while (!(imem_req && pc >= 8'd3) && n < 40) begin tick(1); n++; end
    check("midfetch_reached", {31'b0, imem_req}, 32'd1);
    #1 rst = 1'b1;
    #1 check("midfetch_rst_zero", all_out, 32'h0);
    saved = we_log.size();
    tick(2);
    check("midfetch_no_write", we_log.size(), saved);
    rst = 1'b0;
    n = 0;
    while (!imem_req && n < 10) begin tick(1); n++; end
    check("midfetch_restart_addr", {23'b0, imem_req, imem_addr}, 32'h100);

    // Reset mid-exec
    n = 0;
    while (!(rf_we && pc >= 8'd2) && n < 40) begin tick(1); n++; end
    check("midexec_reached", {31'b0, rf_we}, 32'd1);
    saved = we_log.size();
    #1 rst = 1'b1;
    #1 check("midexec_rst_zero", all_out, 32'h0);
    tick(2);
    check("midexec_no_write", we_log.size(), saved);
    rst = 1'b0;
    n = 0;
    while (!imem_req && n < 10) begin tick(1); n++; end
    check("midexec_restart_addr", {23'b0, imem_req, imem_addr}, 32'h100);
    run = 1'b0;
    tick(4);

    check("decode_quiet_outside_exec", quiet_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quick_cpu_sequencer.md
QUICK_CPU_SEQUENCER -- requirements
Module: quick_cpu_sequencer

Interface
REQ-001 Parameter PC_W, default 8, program counter and instruction-address width.
REQ-002 Parameter TMO, default 15, fetch-timeout limit in cycles (1..15).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset; asserts immediately, deasserts synchronously to clk.
REQ-005 run  in  1  level; 1 = free-run instructions back to back.
REQ-006 step  in  1  1-cycle pulse; executes exactly one instruction from IDLE.
REQ-007 imem_req  out  1  fetch request to program memory.
REQ-008 imem_addr  out  PC_W  fetch address (equals pc).
REQ-009 imem_ack  in  1  memory accept/data-valid, sampled only while imem_req=1.
REQ-010 imem_rdata  in  8  instruction byte, valid when imem_ack=1.
REQ-011 rf_we  out  1  register-file write strobe, 1 cycle wide.
REQ-012 rf_sel  out  1  destination register: 0 = A, 1 = B.
REQ-013 rf_src  out  1  write source: 0 = ALU result, 1 = imm.
REQ-014 imm  out  8  zero-extended immediate.
REQ-015 alu_op  out  2  ALU operation select passed to datapath.
REQ-016 pc  out  PC_W  current program counter.
REQ-017 halted  out  1  1 in HALT state.
REQ-018 fault  out  1  sticky fetch-timeout flag.

Function
REQ-019 Instruction encoding: [7:6] opcode; 00 ALU (alu_op=[5:4], rf_sel=[3]); 01 LDI (rf_sel=[5], imm={3'b0,[4:0]}); 10 JMP (target={2'b0,[5:0]}); 11 HALT.
REQ-020 States: IDLE, FETCH, EXEC, HALT; encoding free.
REQ-021 IDLE -> FETCH when run=1 or step=1; step captured into a one-shot flag; otherwise stay.
REQ-022 FETCH: imem_req=1, imem_addr=pc held stable until imem_ack; on ack latch imem_rdata into instruction register, -> EXEC.
REQ-023 Fetch timeout: cycle counter clears on entry to FETCH; if TMO cycles elapse with no ack, set fault=1 and -> HALT.
REQ-024 EXEC lasts exactly 1 cycle; ALU/LDI assert rf_we=1 with rf_sel/rf_src/imm/alu_op decoded from latched instruction; JMP and HALT assert rf_we=0.
REQ-025 EXEC pc update: ALU/LDI pc <= pc+1 modulo 2^PC_W (wraps 255 -> 0); JMP pc <= target; HALT pc unchanged.
REQ-026 EXEC next state: HALT opcode -> HALT; else run=1 and no pending step -> FETCH; else -> IDLE and clear step flag.
REQ-027 Latency: imem_ack at cycle N -> rf_we=1 at cycle N+1; next imem_req=1 at N+2 in free-run.
REQ-028 HALT is terminal: outputs quiescent (imem_req=0, rf_we=0), halted=1; only rst exits.
REQ-029 step while run=1 is ignored; step while not in IDLE is ignored.
REQ-030 Deasserting run during FETCH completes the current fetch and execute, then -> IDLE.
REQ-031 imem_ack while imem_req=0 is ignored.
REQ-032 rf_sel, rf_src, imm, alu_op are 0 outside EXEC.

Reset
REQ-033 rst=1 forces IDLE, pc=0, instruction register=0, step flag=0, timeout counter=0, fault=0.
REQ-034 During rst all outputs are 0: imem_req, imem_addr, rf_we, rf_sel, rf_src, imm, alu_op, pc, halted, fault.
REQ-035 rst asserted mid-fetch or mid-EXEC aborts without a write; the first request after release is at address 0.

Verification
REQ-036 Memory {0x45, 0x61, 0x00, 0xC0}, ack 1 cycle after req, run=1 -> writes A=5 (imm), B=1 (imm), ALU op0 into A; halted=1 with pc=3.
REQ-037 Memory[0]=0x45, run=0, one step pulse -> exactly one fetch at address 0, one rf_we, pc=1, back in IDLE, no further imem_req.
REQ-038 Memory[0]=0x8A (JMP 10), run=1 -> next imem_addr=10; pc=255 with ALU instruction -> pc wraps to 0.
REQ-039 run=1, imem_ack held 0 -> fault=1, halted=1 after TMO=15 cycles in FETCH, no rf_we.
REQ-040 rst pulse while imem_req=1 -> all outputs 0 immediately; after release, run=1 gives imem_addr=0.
